// File: rtl/audio_fifo_pkg.sv
// Shared types and helpers for the multi-channel audio sample FIFO bank.
package audio_fifo_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } fifo_state_e;

  localparam int UNDERFLOW_ZERO = 0;
  localparam int UNDERFLOW_HOLD = 1;

  // Level counters need one extra bit so that a completely full FIFO is representable.
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sample_fifo_ch.sv
// Single-channel synchronous FIFO: inferred RAM, occupancy level, push/pop and flush.
module sample_fifo_ch
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int LVL_W = lvl_w(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [LVL_W-1:0]  level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  lvl_q;
  logic              push;
  logic              pop_ok;

  // Readiness comes from the registered level only, so a full FIFO refuses a push
  // even when a pop frees a slot in the same cycle.
  assign wr_ready = (lvl_q != LVL_W'(DEPTH));
  assign push     = wr_valid && wr_ready && !flush;
  assign pop_ok   = pop && (lvl_q != '0) && !flush;
  assign rd_data  = mem[rd_ptr];
  assign level    = lvl_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      lvl_q  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      lvl_q <= lvl_q + LVL_W'(push) - LVL_W'(pop_ok);
    end
  end

endmodule

// File: rtl/audio_sample_fifo_bank.sv
// Multi-channel audio sample buffer: per-channel FIFOs popped in lockstep on the codec
// frame tick, with prefill/run control, underflow substitution, sticky flags and flush.
module audio_sample_fifo_bank
  import audio_fifo_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int NUM_CH         = 2,
  parameter int DEPTH          = 256,
  parameter int PREFILL        = 128,
  parameter int AF_THRESH      = 248,
  parameter int UNDERFLOW_MODE = UNDERFLOW_ZERO,
  parameter int REFILL_ON_UF   = 1,
  localparam int LVL_W         = lvl_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     sample_tick,
  output logic                     out_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH*LVL_W-1:0]  level,
  output logic [NUM_CH-1:0]        almost_full,
  output logic [NUM_CH-1:0]        underflow,
  input  logic                     clear_flags,
  input  logic                     flush,
  output logic                     running
);

  fifo_state_e              state_q;
  logic                     vld_p1;
  logic [NUM_CH*DATA_W-1:0] data_p1;
  logic [NUM_CH*DATA_W-1:0] frame_p0;
  logic [NUM_CH-1:0]        uf_q;
  logic [NUM_CH-1:0]        uf_set;
  logic [NUM_CH-1:0]        pop;
  logic [NUM_CH-1:0]        empty;
  logic [NUM_CH-1:0]        prefilled;
  logic [DATA_W-1:0]        rd_ch   [NUM_CH];
  logic [DATA_W-1:0]        last_q  [NUM_CH];
  logic [LVL_W-1:0]         lvl_ch  [NUM_CH];
  logic                     run_tick;

  function automatic logic [DATA_W-1:0] substitute(input logic [DATA_W-1:0] last);
    return (UNDERFLOW_MODE == UNDERFLOW_HOLD) ? last : '0;
  endfunction

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sample_fifo_ch #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .wr_valid (in_valid[c]),
      .wr_data  (in_data[c*DATA_W +: DATA_W]),
      .wr_ready (in_ready[c]),
      .pop      (pop[c]),
      .rd_data  (rd_ch[c]),
      .level    (lvl_ch[c])
    );
    assign level[c*LVL_W +: LVL_W] = lvl_ch[c];
    assign almost_full[c]          = (int'(lvl_ch[c]) >= AF_THRESH);
  end

  // Flush wins over a coincident tick: the pulse still goes out, but silent and without popping.
  assign run_tick = sample_tick && (state_q == RUN) && !flush;

  // p0: frame assembly from registered levels and FIFO heads
  always_comb begin
    frame_p0  = '0;
    pop       = '0;
    empty     = '0;
    prefilled = '0;
    uf_set    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c]     = (lvl_ch[c] == '0);
      prefilled[c] = (int'(lvl_ch[c]) >= PREFILL);
      pop[c]       = run_tick && !empty[c];
      uf_set[c]    = run_tick && empty[c];
      if (run_tick)
        frame_p0[c*DATA_W +: DATA_W] = empty[c] ? substitute(last_q[c]) : rd_ch[c];
    end
  end

  // p1: registered frame, flags and run/fill control
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      uf_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) last_q[c] <= '0;
    end else begin
      vld_p1 <= sample_tick;
      if (sample_tick) data_p1 <= frame_p0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (pop[c]) last_q[c] <= rd_ch[c];
      end
      uf_q <= (uf_q & ~{NUM_CH{clear_flags}}) | uf_set;
      if (flush) begin
        state_q <= FILL;
      end else if (state_q == FILL) begin
        if (&prefilled) state_q <= RUN;
      end else if ((REFILL_ON_UF != 0) && (|uf_set)) begin
        state_q <= FILL;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign underflow = uf_q;
  assign running   = (state_q == RUN);

endmodule

// File: tb/tb_audio_sample_fifo_bank.sv
// Bench for audio_sample_fifo_bank: directed vectors on a 2-channel instance and a
// randomized stream on a 4-channel, 16-deep instance against a queue-based reference.
module tb_audio_sample_fifo_bank;
  import audio_fifo_pkg::*;

  localparam int ALW = 9;
  localparam int BNC = 4;
  localparam int BD  = 16;
  localparam int BP  = 8;
  localparam int BAF = 14;
  localparam int BLW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Instance A: 2 channels, 256 deep, hold-last substitution
  logic [1:0]  a_in_valid = '0;
  logic [63:0] a_in_data = '0;
  logic [1:0]  a_in_ready;
  logic        a_tick = 1'b0;
  logic        a_out_valid;
  logic [63:0] a_out_data;
  logic [17:0] a_level;
  logic [1:0]  a_af;
  logic [1:0]  a_uf;
  logic        a_clear = 1'b0;
  logic        a_flush = 1'b0;
  logic        a_running;

  // Instance B: 4 channels, 16 deep, zero substitution
  logic [3:0]   b_in_valid = '0;
  logic [127:0] b_in_data = '0;
  logic [3:0]   b_in_ready;
  logic         b_tick = 1'b0;
  logic         b_out_valid;
  logic [127:0] b_out_data;
  logic [19:0]  b_level;
  logic [3:0]   b_af;
  logic [3:0]   b_uf;
  logic         b_clear = 1'b0;
  logic         b_flush = 1'b0;
  logic         b_running;

  audio_sample_fifo_bank #(
    .DATA_W(32), .NUM_CH(2), .DEPTH(256), .PREFILL(128), .AF_THRESH(248),
    .UNDERFLOW_MODE(UNDERFLOW_HOLD), .REFILL_ON_UF(1)
  ) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .sample_tick(a_tick), .out_valid(a_out_valid),
    .out_data(a_out_data), .level(a_level), .almost_full(a_af), .underflow(a_uf),
    .clear_flags(a_clear), .flush(a_flush), .running(a_running)
  );

  audio_sample_fifo_bank #(
    .DATA_W(32), .NUM_CH(BNC), .DEPTH(BD), .PREFILL(BP), .AF_THRESH(BAF),
    .UNDERFLOW_MODE(UNDERFLOW_ZERO), .REFILL_ON_UF(1)
  ) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .sample_tick(b_tick), .out_valid(b_out_valid),
    .out_data(b_out_data), .level(b_level), .almost_full(b_af), .underflow(b_uf),
    .clear_flags(b_clear), .flush(b_flush), .running(b_running)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic t, input logic fl, input logic clr);
    a_in_valid = v;
    a_in_data  = {d1, d0};
    a_tick     = t;
    a_flush    = fl;
    a_clear    = clr;
  endtask

  function automatic logic [8:0] a_lvl(input int c);
    return a_level[c*ALW +: ALW];
  endfunction

  // Reference model for instance B: one queue per channel plus run/fill and flag state
  logic [31:0]  mq [BNC][$];
  logic [31:0]  m_last [BNC];
  bit           m_run;
  logic [3:0]   m_uf;
  logic         m_ov;
  logic [127:0] m_od;

  task automatic model_reset();
    for (int c = 0; c < BNC; c++) begin
      mq[c].delete();
      m_last[c] = '0;
    end
    m_run = 0;
    m_uf  = '0;
    m_ov  = 1'b0;
    m_od  = '0;
  endtask

  task automatic model_step(input logic [3:0] v, input logic [127:0] d, input logic t,
                            input logic fl, input logic clr);
    int sz [BNC];
    bit all_ok;
    logic [3:0] set;
    all_ok = 1;
    set = '0;
    for (int c = 0; c < BNC; c++) begin
      sz[c] = mq[c].size();
      if (sz[c] < BP) all_ok = 0;
    end
    m_ov = t;
    if (fl) begin
      if (t) m_od = '0;
      for (int c = 0; c < BNC; c++) mq[c].delete();
      m_run = 0;
    end else begin
      if (t) begin
        for (int c = 0; c < BNC; c++) begin
          if (!m_run) begin
            m_od[c*32 +: 32] = '0;
          end else if (sz[c] > 0) begin
            m_last[c] = mq[c].pop_front();
            m_od[c*32 +: 32] = m_last[c];
          end else begin
            set[c] = 1'b1;
            m_od[c*32 +: 32] = '0;
          end
        end
      end
      for (int c = 0; c < BNC; c++)
        if (v[c] && sz[c] != BD) mq[c].push_back(d[c*32 +: 32]);
      if (!m_run) begin
        if (all_ok) m_run = 1;
      end else if (|set) begin
        m_run = 0;
      end
    end
    m_uf = (clr ? 4'b0 : m_uf) | set;
  endtask

  int exp_seq [BNC];
  logic [3:0] b_acc;

  task automatic b_step_check();
    logic [3:0]   cv;
    logic [127:0] cd;
    logic         ct;
    logic         ccl;
    logic [3:0]   crdy;
    logic [19:0]  elvl;
    logic [3:0]   erdy;
    logic [3:0]   eaf;
    logic [31:0]  x;
    cv = b_in_valid; cd = b_in_data; ct = b_tick; ccl = b_clear; crdy = b_in_ready;
    step();
    model_step(cv, cd, ct, 1'b0, ccl);
    b_acc = cv & crdy;
    for (int c = 0; c < BNC; c++) begin
      elvl[c*BLW +: BLW] = BLW'(mq[c].size());
      erdy[c] = (mq[c].size() != BD);
      eaf[c]  = (mq[c].size() >= BAF);
    end
    chk("b_out_valid", b_out_valid, m_ov);
    if (m_ov) chk("b_out_data", b_out_data, m_od);
    chk("b_level", b_level, elvl);
    chk("b_in_ready", b_in_ready, erdy);
    chk("b_almost_full", b_af, eaf);
    chk("b_underflow", b_uf, m_uf);
    chk("b_running", b_running, m_run);
    if (b_out_valid) begin
      for (int c = 0; c < BNC; c++) begin
        x = b_out_data[c*32 +: 32];
        if (x != 0) begin
          chk($sformatf("b_seq_ch%0d", c), x, exp_seq[c]);
          exp_seq[c] = int'(x) + 1;
        end
      end
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0, d1;
    logic        tick, flush, clr;
    logic        ov;
    logic [63:0] od;
    logic [8:0]  l0, l1;
    logic        run;
    logic [1:0]  uf;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                              input logic t, input logic fl, input logic clr, input logic ov,
                              input logic [8:0] l0, input logic [8:0] l1);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.tick = t; r.flush = fl; r.clr = clr;
    r.ov = ov; r.od = '0; r.l0 = l0; r.l1 = l1; r.run = 1'b0; r.uf = 2'b00;
    return r;
  endfunction

  vec_t tbl [6];

  initial begin
    int tcnt;
    bit done;
    int nxt [BNC];
    logic [8:0] el;

    tbl[0] = mk(2'b11, 32'h11, 32'h21, 0, 0, 0, 0, 1, 1);
    tbl[1] = mk(2'b01, 32'h12, 32'h22, 0, 0, 0, 0, 2, 1);
    tbl[2] = mk(2'b10, 32'h12, 32'h22, 1, 0, 0, 1, 2, 2);
    tbl[3] = mk(2'b00, 32'h0,  32'h0,  0, 0, 0, 0, 2, 2);
    tbl[4] = mk(2'b11, 32'h13, 32'h23, 1, 1, 0, 1, 0, 0);
    tbl[5] = mk(2'b11, 32'h14, 32'h24, 0, 0, 1, 0, 1, 1);

    model_reset();
    reset = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_out_data", a_out_data, 64'h0);
    chk("rst_level", a_level, 18'h0);
    chk("rst_running", a_running, 1'b0);
    chk("rst_underflow", a_uf, 2'b00);
    chk("rst_in_ready", a_in_ready, 2'b11);
    chk("rst_b_in_ready", b_in_ready, 4'hF);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      drive_a(tbl[i].v, tbl[i].d0, tbl[i].d1, tbl[i].tick, tbl[i].flush, tbl[i].clr);
      step();
      chk($sformatf("tbl%0d_out_valid", i), a_out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_out_data", i), a_out_data, tbl[i].od);
      chk($sformatf("tbl%0d_level0", i), a_lvl(0), tbl[i].l0);
      chk($sformatf("tbl%0d_level1", i), a_lvl(1), tbl[i].l1);
      chk($sformatf("tbl%0d_running", i), a_running, tbl[i].run);
      chk($sformatf("tbl%0d_underflow", i), a_uf, tbl[i].uf);
    end
    drive_a(2'b00, 0, 0, 0, 1, 0);
    step();
    chk("flush_clear_level", a_level, 18'h0);

    // FILL silence with levels below prefill
    for (int i = 0; i < 10; i++) begin
      drive_a(2'b11, 32'h10 + i, 32'h20 + i, 0, 0, 0);
      step();
    end
    drive_a(2'b00, 0, 0, 1, 0, 0);
    step();
    chk("fill_out_valid", a_out_valid, 1'b1);
    chk("fill_out_data", a_out_data, 64'h0);
    chk("fill_level0", a_lvl(0), 9'd10);
    chk("fill_level1", a_lvl(1), 9'd10);
    chk("fill_running", a_running, 1'b0);
    drive_a(2'b00, 0, 0, 0, 1, 0);
    step();
    drive_a(2'b00, 0, 0, 0, 0, 0);

    // Prefill to 128, enter RUN, first popped frame
    for (int i = 0; i < 128; i++) begin
      drive_a(2'b11, 32'h100 + i, 32'h200 + i, 0, 0, 0);
      step();
    end
    drive_a(2'b00, 0, 0, 0, 0, 0);
    chk("pre_level0", a_lvl(0), 9'd128);
    chk("pre_running", a_running, 1'b0);
    step();
    chk("run_running", a_running, 1'b1);
    drive_a(2'b00, 0, 0, 1, 0, 0);
    step();
    chk("run_out_valid", a_out_valid, 1'b1);
    chk("run_out_data", a_out_data, {32'h200, 32'h100});
    chk("run_level0", a_lvl(0), 9'd127);
    chk("run_level1", a_lvl(1), 9'd127);
    drive_a(2'b00, 0, 0, 0, 0, 0);
    step();
    chk("run_pulse_end", a_out_valid, 1'b0);
    drive_a(2'b00, 0, 0, 0, 1, 0);
    step();
    chk("flush2_running", a_running, 1'b0);

    // Full boundary on ch0 with almost_full tracking
    for (int i = 0; i < 300; i++) begin
      drive_a(2'b01, 32'h600 + i, 0, 0, 0, 0);
      step();
      el = (i + 1 > 256) ? 9'd256 : 9'(i + 1);
      chk($sformatf("full_level_%0d", i), a_lvl(0), el);
      chk($sformatf("full_af_%0d", i), a_af[0], el >= 9'd248);
      chk($sformatf("full_ready_%0d", i), a_in_ready[0], el != 9'd256);
    end
    for (int i = 0; i < 128; i++) begin
      drive_a(2'b11, 32'hFFFF, 32'h500 + i, 0, 0, 0);
      step();
    end
    chk("full_hold_level0", a_lvl(0), 9'd256);
    step();
    chk("full_run", a_running, 1'b1);
    drive_a(2'b01, 32'hFFFF, 0, 1, 0, 0);
    step();
    chk("full_pop_level0", a_lvl(0), 9'd255);
    chk("full_pop_data", a_out_data, {32'h500, 32'h600});
    chk("full_pop_ready", a_in_ready[0], 1'b1);
    drive_a(2'b01, 32'hFFFF, 0, 0, 0, 0);
    step();
    chk("full_refill_level0", a_lvl(0), 9'd256);

    // Flush with simultaneous tick and push while running
    drive_a(2'b01, 32'hDEAD, 0, 1, 1, 0);
    step();
    chk("flush_out_valid", a_out_valid, 1'b1);
    chk("flush_out_data", a_out_data, 64'h0);
    chk("flush_level", a_level, 18'h0);
    chk("flush_running", a_running, 1'b0);
    drive_a(2'b00, 0, 0, 0, 0, 0);
    step();
    chk("flush_after_level", a_level, 18'h0);

    // Underflow with hold-last substitution
    for (int i = 0; i < 133; i++) begin
      drive_a({i < 128, 1'b1}, 32'h300 + i, (i == 127) ? 32'hABCD : 32'h400 + i, 0, 0, 0);
      step();
    end
    drive_a(2'b00, 0, 0, 0, 0, 0);
    step();
    chk("uf_setup_running", a_running, 1'b1);
    for (int k = 0; k < 128; k++) begin
      drive_a(2'b00, 0, 0, 1, 0, 0);
      step();
      chk($sformatf("drain_data_%0d", k), a_out_data,
          {(k == 127) ? 32'hABCD : 32'h400 + k, 32'h300 + k});
      drive_a(2'b00, 0, 0, 0, 0, 0);
      step();
    end
    chk("uf_pre_level0", a_lvl(0), 9'd5);
    chk("uf_pre_level1", a_lvl(1), 9'd0);
    chk("uf_pre_flag", a_uf, 2'b00);
    drive_a(2'b00, 0, 0, 1, 0, 0);
    step();
    chk("uf_out_valid", a_out_valid, 1'b1);
    chk("uf_out_data", a_out_data, {32'hABCD, 32'h300 + 128});
    chk("uf_flag", a_uf, 2'b10);
    chk("uf_level0", a_lvl(0), 9'd4);
    chk("uf_running", a_running, 1'b0);
    drive_a(2'b00, 0, 0, 0, 1, 0);
    step();
    chk("uf_flush_keeps_flag", a_uf, 2'b10);
    chk("uf_flush_level", a_level, 18'h0);
    drive_a(2'b00, 0, 0, 0, 0, 1);
    step();
    chk("uf_cleared", a_uf, 2'b00);

    // Reset in mid-operation discards contents and suppresses the pulse
    for (int i = 0; i < 3; i++) begin
      drive_a(2'b11, 32'h900 + i, 32'hA00 + i, 0, 0, 0);
      step();
    end
    drive_a(2'b00, 0, 0, 1, 0, 0);
    reset = 1'b1;
    step();
    model_reset();
    chk("midrst_out_valid", a_out_valid, 1'b0);
    chk("midrst_level", a_level, 18'h0);
    chk("midrst_ready", a_in_ready, 2'b11);
    reset = 1'b0;
    drive_a(2'b00, 0, 0, 0, 0, 0);
    step();

    // Randomized wrap-around stream on instance B
    for (int c = 0; c < BNC; c++) begin
      nxt[c] = 1;
      exp_seq[c] = 1;
    end
    tcnt = 4;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      done = 1;
      for (int c = 0; c < BNC; c++) if (nxt[c] <= 1000) done = 0;
      if (done) break;
      for (int c = 0; c < BNC; c++) begin
        if (!b_in_valid[c] && nxt[c] <= 1000 && $urandom_range(0, 9) < 7) begin
          b_in_valid[c] = 1'b1;
          b_in_data[c*32 +: 32] = 32'(nxt[c]);
        end
      end
      if (tcnt == 0) begin
        b_tick = 1'b1;
        tcnt = $urandom_range(2, 4);
      end else begin
        b_tick = 1'b0;
        tcnt--;
      end
      b_step_check();
      for (int c = 0; c < BNC; c++) begin
        if (b_acc[c]) begin
          b_in_valid[c] = 1'b0;
          nxt[c]++;
        end
      end
    end
    chk("b_stream_done", done, 1'b1);
    chk("b_stream_no_underflow", b_uf, 4'h0);
    for (int c = 0; c < BNC; c++)
      chk($sformatf("b_no_loss_ch%0d", c), 32'(exp_seq[c]) + 32'(b_level[c*BLW +: BLW]), 32'd1001);

    // Drain into underflow with zero substitution and random flag clears
    b_in_valid = '0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      b_tick  = (cyc % 4 == 0);
      b_clear = ($urandom_range(0, 9) == 0);
      b_step_check();
    end
    b_tick = 1'b0;
    b_clear = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
